// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC selection and PC-register strobes for the fetch stage.
// Picks sequential, jump/branch, exception-vector or EPC-return as the next PC,
// tracks EPC and the exception level, and freezes the PC for FLUSH_CYCLES
// cycles after every exception entry or eret.
// Optional feature macro: PC_SEQ_DELAY_SLOT_EN (EPC points at the branch when
// the faulting instruction sits in a delay slot).
module pc_sequencer #(
    parameter logic [31:0] RESET_PC     = 32'h0000_3000,
    parameter logic [31:0] EXC_VEC      = 32'h0000_4180,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic        stall,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        in_delay_slot,
    input  logic        exc_req,
    input  logic        eret,
    output logic [31:0] Npc,
    output logic        PCEn,
    output logic        PCtoIn,
    output logic        PCBack,
    output logic        flush,
    output logic [31:0] epc,
    output logic        exl,
    output logic        exc_dropped
);

    typedef enum logic [0:0] {StRun, StHold} state_e;

    localparam logic [3:0] FlushCnt = 4'(FLUSH_CYCLES);

    state_e      r_state, w_state_d;
    logic [3:0]  r_cnt, w_cnt_d;
    logic        r_exl, w_exl_d;
    logic [31:0] r_epc, w_epc_d;
    logic [31:0] w_epc_capture;

`ifdef PC_SEQ_DELAY_SLOT_EN
    // Faulting delay-slot instruction: return to the branch so it re-executes.
    assign w_epc_capture = in_delay_slot ? (pc - 32'd4) : pc;
`else
    logic w_unused_in_delay_slot;
    assign w_unused_in_delay_slot = in_delay_slot;
    assign w_epc_capture          = pc;
`endif

    assign epc = r_epc;
    assign exl = r_exl;

    // State, hold counter, EXL and EPC registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StRun;
            r_cnt   <= 4'd0;
            r_exl   <= 1'b0;
            r_epc   <= RESET_PC;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_exl   <= w_exl_d;
            r_epc   <= w_epc_d;
        end
    end

    // Next-PC priority selection, strobes and next-state logic.
    always_comb begin
        w_state_d   = r_state;
        w_cnt_d     = r_cnt;
        w_exl_d     = r_exl;
        w_epc_d     = r_epc;
        Npc         = pc;
        PCEn        = 1'b0;
        PCtoIn      = 1'b0;
        PCBack      = 1'b0;
        flush       = 1'b0;
        exc_dropped = 1'b0;

        if (reset) begin
            Npc = RESET_PC;
        end else begin
            case (r_state)
                StRun: begin
                    if (exc_req && !r_exl) begin
                        PCtoIn    = 1'b1;
                        flush     = 1'b1;
                        Npc       = EXC_VEC;
                        w_epc_d   = w_epc_capture;
                        w_exl_d   = 1'b1;
                        w_cnt_d   = FlushCnt;
                        w_state_d = StHold;
                    end else begin
                        // Masked exception: report it, let the rest proceed.
                        exc_dropped = exc_req;
                        if (eret && r_exl) begin
                            PCBack    = 1'b1;
                            flush     = 1'b1;
                            Npc       = r_epc;
                            w_exl_d   = 1'b0;
                            w_cnt_d   = FlushCnt;
                            w_state_d = StHold;
                        end else if (stall) begin
                            Npc = pc;
                        end else if (jump) begin
                            PCEn = 1'b1;
                            Npc  = {jump_target[31:2], 2'b00};
                        end else if (branch_taken) begin
                            PCEn = 1'b1;
                            Npc  = {branch_target[31:2], 2'b00};
                        end else begin
                            PCEn = 1'b1;
                            Npc  = pc + 32'd4;
                        end
                    end
                end
                StHold: begin
                    w_cnt_d = r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        w_state_d = StRun;
                    end
                end
                default: begin
                    w_state_d = StRun;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: a behavioural model pushes the expected
// outputs for each driven cycle to a queue; they are popped and compared at the
// falling edge.
module tb_pc_sequencer;

    localparam logic [31:0] ResetPc = 32'h0000_3000;
    localparam logic [31:0] ExcVec  = 32'h0000_4180;
    localparam int          Flush   = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic        stall, jump, branch_taken, in_delay_slot, exc_req, eret;
    logic [31:0] jump_target, branch_target;
    logic [31:0] Npc, epc;
    logic        PCEn, PCtoIn, PCBack, flush, exl, exc_dropped;

    typedef struct packed {
        logic [31:0] npc;
        logic        pcen;
        logic        pctoin;
        logic        pcback;
        logic        flush;
        logic        dropped;
        logic [31:0] epc;
        logic        exl;
    } exp_t;

    exp_t q_exp[$];

    int n_checks = 0;
    int n_fail   = 0;
    bit follow   = 1'b0;

    // Model state.
    bit          m_hold;
    int          m_cnt;
    bit          m_exl;
    logic [31:0] m_epc;

    pc_sequencer #(
        .RESET_PC    (ResetPc),
        .EXC_VEC     (ExcVec),
        .FLUSH_CYCLES(Flush)
    ) u_dut (
        .clk          (clk),
        .reset        (reset),
        .pc           (pc),
        .stall        (stall),
        .jump         (jump),
        .jump_target  (jump_target),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .in_delay_slot(in_delay_slot),
        .exc_req      (exc_req),
        .eret         (eret),
        .Npc          (Npc),
        .PCEn         (PCEn),
        .PCtoIn       (PCtoIn),
        .PCBack       (PCBack),
        .flush        (flush),
        .epc          (epc),
        .exl          (exl),
        .exc_dropped  (exc_dropped)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_hold = 1'b0;
        m_cnt  = 0;
        m_exl  = 1'b0;
        m_epc  = ResetPc;
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e         = '0;
        e.epc     = m_epc;
        e.exl     = m_exl;
        e.npc     = pc;
        if (reset) begin
            e.npc = ResetPc;
        end else if (m_hold) begin
            e.npc = pc;
        end else if (exc_req && !m_exl) begin
            e.pctoin = 1'b1;
            e.flush  = 1'b1;
            e.npc    = ExcVec;
        end else begin
            e.dropped = exc_req;
            if (eret && m_exl) begin
                e.pcback = 1'b1;
                e.flush  = 1'b1;
                e.npc    = m_epc;
            end else if (stall) begin
                e.npc = pc;
            end else if (jump) begin
                e.pcen = 1'b1;
                e.npc  = jump_target & 32'hFFFF_FFFC;
            end else if (branch_taken) begin
                e.pcen = 1'b1;
                e.npc  = branch_target & 32'hFFFF_FFFC;
            end else begin
                e.pcen = 1'b1;
                e.npc  = pc + 32'd4;
            end
        end
        return e;
    endfunction

    task automatic model_edge();
        if (reset) begin
            model_reset();
        end else if (m_hold) begin
            if (m_cnt == 1) m_hold = 1'b0;
            m_cnt--;
        end else if (exc_req && !m_exl) begin
`ifdef PC_SEQ_DELAY_SLOT_EN
            m_epc = in_delay_slot ? pc - 32'd4 : pc;
`else
            m_epc = pc;
`endif
            m_exl  = 1'b1;
            m_cnt  = Flush;
            m_hold = 1'b1;
        end else if (eret && m_exl) begin
            m_exl  = 1'b0;
            m_cnt  = Flush;
            m_hold = 1'b1;
        end
    endtask

    // One cycle: predict, compare at the falling edge, advance the model.
    task automatic step(input string tag);
        exp_t e, p;
        e = model_out();
        q_exp.push_back(e);
        @(negedge clk);
        p = q_exp.pop_front();
        check_eq({tag, ".Npc"}, Npc, p.npc);
        check_eq({tag, ".PCEn"}, 32'(PCEn), 32'(p.pcen));
        check_eq({tag, ".PCtoIn"}, 32'(PCtoIn), 32'(p.pctoin));
        check_eq({tag, ".PCBack"}, 32'(PCBack), 32'(p.pcback));
        check_eq({tag, ".flush"}, 32'(flush), 32'(p.flush));
        check_eq({tag, ".exc_dropped"}, 32'(exc_dropped), 32'(p.dropped));
        check_eq({tag, ".epc"}, epc, p.epc);
        check_eq({tag, ".exl"}, 32'(exl), 32'(p.exl));
        @(posedge clk);
        model_edge();
        #1;
        if (follow && (p.pcen || p.pctoin || p.pcback)) pc = p.npc;
    endtask

    task automatic idle_inputs();
        stall = 0; jump = 0; branch_taken = 0; in_delay_slot = 0; exc_req = 0; eret = 0;
        jump_target = '0; branch_target = '0;
    endtask

    initial begin
        model_reset();
        reset = 1'b1;
        pc    = 32'h0;
        idle_inputs();
        @(posedge clk); #1;
        step("rst_hold");
        check_eq("rst.Npc_const", Npc, ResetPc);

        // Reset release, free-running sequential fetch.
        reset  = 1'b0;
        pc     = ResetPc;
        follow = 1'b1;
        for (int i = 0; i < 3; i++) step("seq");
        check_eq("seq.pc_advanced", pc, 32'h0000_300C);
        follow = 1'b0;

        // Stall beats jump, then jump taken, target alignment, jump beats branch.
        pc = 32'h3010; stall = 1; jump = 1; jump_target = 32'h3400;
        step("stall_jump");
        stall = 0;
        step("jump");
        jump_target = 32'h3403;
        step("jump_align");
        branch_taken = 1; branch_target = 32'h3500;
        step("jump_over_branch");
        jump = 0; branch_target = 32'h3507;
        step("branch");
        branch_taken = 0;

        // Exception entry overrides stall, then the hold window.
        pc = 32'h3020; exc_req = 1; stall = 1;
        step("exc_entry");
        stall = 0;
        eret  = 1;
        step("hold1_reqs_ignored");
        exc_req = 0; eret = 0;
        step("hold2");
        step("after_hold");

        // In handler: masked exception, then eret together with exception.
        pc = 32'h4180; exc_req = 1;
        step("exc_dropped");
        eret = 1;
        step("eret_with_exc");
        exc_req = 0; eret = 0;
        step("eret_hold1");
        step("eret_hold2");
        eret = 1; pc = 32'h3024;
        step("lone_eret");
        eret = 0;

        // Sequential wrap.
        pc = 32'hFFFF_FFFC;
        step("wrap");

        // Delay-slot exception, then reset in the middle of the hold.
        pc = 32'h3044; in_delay_slot = 1; exc_req = 1;
        step("exc_delay_slot");
        exc_req = 0; in_delay_slot = 0;
        step("ds_hold1");
`ifdef PC_SEQ_DELAY_SLOT_EN
        check_eq("ds.epc", epc, 32'h0000_3040);
`else
        check_eq("ds.epc", epc, 32'h0000_3044);
`endif
        reset = 1'b1;
        #1;
        check_eq("async_rst.Npc", Npc, ResetPc);
        check_eq("async_rst.exl", 32'(exl), 32'd0);
        check_eq("async_rst.strobes", {29'd0, PCEn, PCtoIn, PCBack}, 32'd0);
        model_reset();
        step("rst_mid_hold");
        reset = 1'b0; pc = ResetPc;
        step("post_rst_run");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global timeout guard.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
